mem_access_ctrl: RTL and testbench

- Sequences one memory transaction for the processor datapath:
  - loads MAR from the bus;
  - loads MDR from the bus on a write, or from memory on a read;
  - runs a req/ack handshake with the memory.
- Sits between the control unit (which issues single read/write requests) and the MAR/MDR registers plus the memory port.
- Drives only the register load enables and the MDR source select. It carries no data itself.

---
 rtl/mem_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR/MDR load enables and the memory req/ack handshake.
// Optional MEM_TIMEOUT_EN aborts RD/WR after TIMEOUT_CYCLES without an accepted ack.
module mem_access_ctrl #(
    parameter int unsigned MIN_WAIT       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic req_rd,
    input  logic req_wr,
    input  logic mem_ack,
    output logic MARin,
    output logic MDRin,
    output logic read,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {StIdle, StMar, StWdata, StRd, StWr, StDone} state_e;

    localparam logic [3:0] MinWait = 4'(MIN_WAIT);

    if (MIN_WAIT > 15 || TIMEOUT_CYCLES <= MIN_WAIT) begin : g_bad_cfg
        $error("mem_access_ctrl: MIN_WAIT must be <= 15 and < TIMEOUT_CYCLES");
    end

    state_e     state_q, state_d;
    logic       op_rd_q, op_rd_d;
    logic [3:0] wait_q, wait_d;
    logic       in_access;
    logic       ack_ok;
    logic       tmo_hit;
    logic       aborted;

    assign in_access = (state_q == StRd) || (state_q == StWr);
    assign ack_ok    = in_access && mem_ack && (wait_q >= MinWait);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned      TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            abort_q;

    // An ack in the final counted cycle still completes normally.
    assign tmo_hit = in_access && !ack_ok && (tmo_q == TmoLast);
    assign tmo_d   = in_access ? tmo_q + TmoW'(1) : '0;
    assign aborted = abort_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            tmo_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            abort_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign aborted = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            op_rd_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_rd_q <= op_rd_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_rd_d = op_rd_q;
        // Zero outside RD/WR, so it is already clear on entry; saturates at 15.
        wait_d  = '0;
        if (in_access) begin
            wait_d = (wait_q == 4'd15) ? wait_q : wait_q + 4'd1;
        end
        MARin  = 1'b0;
        MDRin  = 1'b0;
        read   = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Read has priority; a simultaneous write is dropped.
                if (req_rd) begin
                    op_rd_d = 1'b1;
                    state_d = StMar;
                end else if (req_wr) begin
                    op_rd_d = 1'b0;
                    state_d = StMar;
                end
            end
            StMar: begin
                MARin   = 1'b1;
                busy    = 1'b1;
                state_d = op_rd_q ? StRd : StWdata;
            end
            StWdata: begin
                MDRin   = 1'b1;
                busy    = 1'b1;
                state_d = StWr;
            end
            StRd: begin
                mem_rd = 1'b1;
                read   = 1'b1;
                busy   = 1'b1;
                MDRin  = ack_ok;
                if (ack_ok || tmo_hit) begin
                    state_d = StDone;
                end
            end
            StWr: begin
                mem_wr = 1'b1;
                busy   = 1'b1;
                if (ack_ok || tmo_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                busy    = 1'b1;
                err     = aborted;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MIN_WAIT 0 and 2) against a cycle-index model,
// plus literal checks pinning the main sequences. Define MEM_TIMEOUT_EN to test the abort path.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif
    localparam int Tmo = 16;

    logic clock = 1'b0;
    logic clear = 1'b0;
    logic req_rd = 1'b0;
    logic req_wr = 1'b0;
    logic mem_ack = 1'b0;

    logic a_marin, a_mdrin, a_read, a_memrd, a_memwr, a_busy, a_done, a_err;
    logic b_marin, b_mdrin, b_read, b_memrd, b_memwr, b_busy, b_done, b_err;
    // {MARin, MDRin, read, mem_rd, mem_wr, busy, done, err}
    logic [7:0] o0, o2;
    assign o0 = {a_marin, a_mdrin, a_read, a_memrd, a_memwr, a_busy, a_done, a_err};
    assign o2 = {b_marin, b_mdrin, b_read, b_memrd, b_memwr, b_busy, b_done, b_err};

    mem_access_ctrl #(.MIN_WAIT(0), .TIMEOUT_CYCLES(Tmo)) dut0 (
        .clock(clock), .clear(clear), .req_rd(req_rd), .req_wr(req_wr), .mem_ack(mem_ack),
        .MARin(a_marin), .MDRin(a_mdrin), .read(a_read), .mem_rd(a_memrd),
        .mem_wr(a_memwr), .busy(a_busy), .done(a_done), .err(a_err)
    );

    mem_access_ctrl #(.MIN_WAIT(2), .TIMEOUT_CYCLES(Tmo)) dut2 (
        .clock(clock), .clear(clear), .req_rd(req_rd), .req_wr(req_wr), .mem_ack(mem_ack),
        .MARin(b_marin), .MDRin(b_mdrin), .read(b_read), .mem_rd(b_memrd),
        .mem_wr(b_memwr), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Transaction model: k counts cycles since the request was taken (1 = MAR cycle);
    // fin means the coming cycle is the completion pulse.
    typedef struct {
        bit busy;
        bit is_rd;
        int k;
        bit fin;
        bit err;
    } mdl_t;

    function automatic void model(input int mw, input mdl_t s, input bit rr, input bit rw,
                                  input bit ack, output logic [7:0] e, output mdl_t n);
        int a;
        bit acc;
        n = s;
        e = '0;
        if (!s.busy) begin
            if (rr || rw) begin
                n.busy  = 1'b1;
                n.is_rd = rr;
                n.k     = 1;
                n.fin   = 1'b0;
                n.err   = 1'b0;
            end
        end else if (s.fin) begin
            e[2] = 1'b1;
            e[1] = 1'b1;
            e[0] = s.err;
            n.busy = 1'b0;
            n.fin  = 1'b0;
            n.err  = 1'b0;
        end else begin
            e[2] = 1'b1;
            a = s.k - (s.is_rd ? 2 : 3);
            if (s.k == 1) begin
                e[7] = 1'b1;
            end else if (a < 0) begin
                e[6] = 1'b1;
            end else begin
                acc  = ack && (a >= mw);
                e[5] = s.is_rd;
                e[4] = s.is_rd;
                e[3] = !s.is_rd;
                e[6] = acc && s.is_rd;
                if (acc) begin
                    n.fin = 1'b1;
                end else if (TmoEn && a == Tmo - 1) begin
                    n.fin = 1'b1;
                    n.err = 1'b1;
                end
            end
            n.k = s.k + 1;
        end
    endfunction

    mdl_t s0 = '{default: 0};
    mdl_t s2 = '{default: 0};

    // Inputs change only at posedge+1, so negedge sees the values the next edge samples.
    always @(negedge clock) begin
        logic [7:0] e0, e2;
        mdl_t n0, n2;
        if (!clear) begin
            s0 = '{default: 0};
            s2 = '{default: 0};
            e0 = '0;
            e2 = '0;
        end else begin
            model(0, s0, req_rd, req_wr, mem_ack, e0, n0);
            model(2, s2, req_rd, req_wr, mem_ack, e2, n2);
            s0 = n0;
            s2 = n2;
        end
        chk("model_mw0", o0, e0);
        chk("model_mw2", o2, e2);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        repeat (6) step();
        mem_ack = 1'b0;
        step();
    endtask

    initial begin
        int nrd, nde, nmdr;
        #2;
        chk("reset_state_mw0", o0, 8'b0000_0000);
        chk("reset_state_mw2", o2, 8'b0000_0000);
        step();
        step();
        clear = 1'b1;
        step();

        // Read, ack on first RD cycle
        req_rd = 1'b1;
        step();
        req_rd = 1'b0;
        #2 chk("rd_mar", o0, 8'b1000_0100);
        step();
        mem_ack = 1'b1;
        #2 chk("rd_ack", o0, 8'b0111_0100);
        step();
        mem_ack = 1'b0;
        #2 chk("rd_done", o0, 8'b0000_0110);
        step();
        #2 chk("rd_idle", o0, 8'b0000_0000);
        drain();

        // Write, ack low 3 WR cycles then high
        req_wr = 1'b1;
        step();
        req_wr = 1'b0;
        #2 chk("wr_mar", o0, 8'b1000_0100);
        step();
        #2 chk("wr_wdata", o0, 8'b0100_0100);
        for (int i = 0; i < 3; i++) begin
            step();
            #2 chk("wr_wait", o0, 8'b0000_1100);
        end
        step();
        mem_ack = 1'b1;
        #2 chk("wr_ack", o0, 8'b0000_1100);
        step();
        mem_ack = 1'b0;
        #2 chk("wr_done_mw0", o0, 8'b0000_0110);
        chk("wr_done_mw2", o2, 8'b0000_0110);
        step();

        // Both requests: read wins
        req_rd = 1'b1;
        req_wr = 1'b1;
        step();
        req_rd = 1'b0;
        req_wr = 1'b0;
        #2 chk("both_mar", o0, 8'b1000_0100);
        step();
        mem_ack = 1'b1;
        #2 chk("both_rd", o0, 8'b0111_0100);
        step();
        mem_ack = 1'b0;
        #2 chk("both_done", o0, 8'b0000_0110);
        drain();

        // MIN_WAIT=2 instance with ack held through RD
        req_rd = 1'b1;
        step();
        req_rd = 1'b0;
        step();
        mem_ack = 1'b1;
        #2 chk("mw_rd0", o2, 8'b0011_0100);
        step();
        #2 chk("mw_rd1", o2, 8'b0011_0100);
        step();
        #2 chk("mw_rd2", o2, 8'b0111_0100);
        step();
        mem_ack = 1'b0;
        #2 chk("mw_done", o2, 8'b0000_0110);
        step();

        // Reset mid-RD, then a normal read
        req_rd = 1'b1;
        step();
        req_rd = 1'b0;
        step();
        #2 chk("pre_reset_rd", o0, 8'b0011_0100);
        clear = 1'b0;
        #1 chk("reset_async_mw0", o0, 8'b0000_0000);
        chk("reset_async_mw2", o2, 8'b0000_0000);
        step();
        clear = 1'b1;
        req_rd = 1'b1;
        step();
        req_rd = 1'b0;
        #2 chk("post_reset_mar", o0, 8'b1000_0100);
        step();
        mem_ack = 1'b1;
        #2 chk("post_reset_ack", o0, 8'b0111_0100);
        step();
        mem_ack = 1'b0;
        #2 chk("post_reset_done", o0, 8'b0000_0110);
        drain();

        // Read with no ack: aborts after 16 RD cycles only when the timeout is built in
        req_rd = 1'b1;
        step();
        req_rd = 1'b0;
        nrd = 0;
        nde = 0;
        nmdr = 0;
        repeat (24) begin
            step();
            #2;
            if (a_memrd) nrd++;
            if (a_done && a_err) nde++;
            if (a_mdrin) nmdr++;
        end
        chk_int("noack_mdrin_cycles", nmdr, 0);
        if (TmoEn) begin
            chk_int("tmo_rd_cycles", nrd, 16);
            chk_int("tmo_done_err", nde, 1);
        end else begin
            chk_int("noack_rd_cycles", nrd, 24);
            chk_int("noack_done_err", nde, 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
